// File: rtl/sapho_fifo_pkg.sv
// Shared definitions for the sapho FIFO: read-mode encodings and sizing helpers.
package sapho_fifo_pkg;

    typedef enum logic {
        READ_REGISTERED = 1'b0,
        READ_SHOWAHEAD  = 1'b1
    } read_mode_e;

    // Occupancy needs one bit more than the pointers so that a completely full FIFO is representable.
    function automatic int cnt_width(input int length);
        return $clog2(length) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sapho_fifo_if.sv
// FIFO access bundle between a sapho I/O port (master) and the FIFO (slave).
interface sapho_fifo_if
    import sapho_fifo_pkg::*;
#(
    parameter int WORD   = 16,
    parameter int LENGTH = 128
);
    logic [WORD-1:0]              data;
    logic                         wrreq;
    logic                         rdreq;
    logic [WORD-1:0]              q;
    logic                         empty;
    logic                         full;
    logic                         almost_empty;
    logic                         almost_full;
    logic [cnt_width(LENGTH)-1:0] usedw;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output data, wrreq, rdreq,
        input  q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
    );

    modport slave (
        input  data, wrreq, rdreq,
        output q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
    );
endinterface

// File: rtl/sapho_fifo_dpram.sv
// Storage array for the FIFO: one synchronous write port and one asynchronous read port.
module sapho_fifo_dpram
    import sapho_fifo_pkg::*;
#(
    parameter int WORD   = 16,
    parameter int LENGTH = 128
) (
    input  logic                      clock,
    input  logic                      we,
    input  logic [$clog2(LENGTH)-1:0] waddr,
    input  logic [WORD-1:0]           wdata,
    input  logic [$clog2(LENGTH)-1:0] raddr,
    output logic [WORD-1:0]           rdata
);
    logic [WORD-1:0] mem [LENGTH];

    // NOTE: the array has no reset on purpose; clearing it would prevent RAM inference, and the occupancy count already marks stale words as invalid.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sapho_fifo.sv
// Synchronous FIFO with exact LENGTH capacity, threshold flags, sticky error flags and selectable read mode.
module sapho_fifo
    import sapho_fifo_pkg::*;
#(
    parameter int WORD      = 16,
    parameter int LENGTH    = 128,
    parameter int AE_LEVEL  = 2,
    parameter int AF_LEVEL  = 126,
    parameter int SHOWAHEAD = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             sclr,
    sapho_fifo_if.slave      bus
);
    localparam int PTR_W = $clog2(LENGTH);
    localparam int CNT_W = cnt_width(LENGTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam read_mode_e MODE = (SHOWAHEAD != 0) ? READ_SHOWAHEAD : READ_REGISTERED;

    if (!is_pow2(LENGTH)) begin : g_bad_length
        $error("sapho_fifo: LENGTH must be a power of two and at least 2");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > LENGTH) begin : g_bad_ae
        $error("sapho_fifo: AE_LEVEL must lie in 0..LENGTH");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > LENGTH) begin : g_bad_af
        $error("sapho_fifo: AF_LEVEL must lie in 0..LENGTH");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WORD-1:0]  rd_data;
    logic             is_empty;
    logic             is_full;
    logic             wr_en;
    logic             rd_en;
    logic             overflow;
    logic             underflow;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_CNT);
    // A clear cycle must not touch the array, so both enables are masked by sclr.
    assign wr_en    = bus.wrreq & ~is_full  & ~sclr;
    assign rd_en    = bus.rdreq & ~is_empty & ~sclr;

    sapho_fifo_dpram #(.WORD(WORD), .LENGTH(LENGTH)) u_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sclr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (bus.wrreq && is_full)  overflow  <= 1'b1;
            if (bus.rdreq && is_empty) underflow <= 1'b1;
        end
    end

    if (MODE == READ_REGISTERED) begin : g_registered
        logic [WORD-1:0] q_reg;

        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n)     q_reg <= '0;
            else if (sclr)  q_reg <= '0;
            else if (rd_en) q_reg <= rd_data;
        end

        assign bus.q = q_reg;
    end else begin : g_showahead
        // Forcing zero while empty keeps q deterministic after reset and clear.
        assign bus.q = is_empty ? '0 : rd_data;
    end

    assign bus.usedw        = count;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (count < AE_CNT);
    assign bus.almost_full  = (count >= AF_CNT);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sapho_fifo.sv
// Checks show-ahead and registered-read FIFO instances against a queue model, fixed vectors and corner sequences.
module tb_sapho_fifo;
    localparam int WORD = 16;
    localparam int LEN  = 4;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic sclr  = 1'b0;

    always #5 clock = ~clock;

    sapho_fifo_if #(.WORD(WORD), .LENGTH(LEN)) bus_sa ();
    sapho_fifo_if #(.WORD(WORD), .LENGTH(LEN)) bus_rg ();

    sapho_fifo #(.WORD(WORD), .LENGTH(LEN), .AE_LEVEL(1), .AF_LEVEL(3), .SHOWAHEAD(1)) dut_sa (
        .clock (clock), .rst_n (rst_n), .sclr (sclr), .bus (bus_sa)
    );
    sapho_fifo #(.WORD(WORD), .LENGTH(LEN), .AE_LEVEL(1), .AF_LEVEL(3), .SHOWAHEAD(0)) dut_rg (
        .clock (clock), .rst_n (rst_n), .sclr (sclr), .bus (bus_rg)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: contents as a queue, plus the last word handed out for registered reads.
    logic [WORD-1:0] mq[$];
    bit              m_ov;
    bit              m_un;
    logic [WORD-1:0] m_last;

    typedef struct {
        logic            wr;
        logic            rd;
        logic [WORD-1:0] d;
        int              usedw;
        logic            empty;
        logic            full;
        logic            af;
        logic            ov;
        logic            un;
        logic            q_sa_care;
        logic [WORD-1:0] q_sa;
        logic [WORD-1:0] q_rg;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov   = 1'b0;
        m_un   = 1'b0;
        m_last = '0;
    endtask

    task automatic model_step(input logic wr, input logic rd, input logic clr, input logic [WORD-1:0] d);
        int size;
        size = mq.size();
        if (clr) begin
            model_reset();
        end else begin
            if (wr && size == LEN) m_ov = 1'b1;
            if (rd && size == 0)   m_un = 1'b1;
            if (rd && size > 0)    m_last = mq.pop_front();
            if (wr && size < LEN)  mq.push_back(d);
        end
    endtask

    task automatic step(input logic wr, input logic rd, input logic clr, input logic [WORD-1:0] d);
        bus_sa.wrreq = wr; bus_sa.rdreq = rd; bus_sa.data = d;
        bus_rg.wrreq = wr; bus_rg.rdreq = rd; bus_rg.data = d;
        sclr = clr;
        @(posedge clock);
        model_step(wr, rd, clr, d);
        #1;
    endtask

    task automatic check_all(input string tag);
        int size;
        size = mq.size();
        check({tag, " sa.usedw"}, 32'(bus_sa.usedw), 32'(size));
        check({tag, " rg.usedw"}, 32'(bus_rg.usedw), 32'(size));
        check({tag, " sa.empty"}, 32'(bus_sa.empty), 32'(size == 0));
        check({tag, " sa.full"},  32'(bus_sa.full),  32'(size == LEN));
        check({tag, " sa.ae"},    32'(bus_sa.almost_empty), 32'(size < 1));
        check({tag, " sa.af"},    32'(bus_sa.almost_full),  32'(size >= 3));
        check({tag, " rg.flags"}, {28'd0, bus_rg.empty, bus_rg.full, bus_rg.almost_empty, bus_rg.almost_full},
              {28'd0, size == 0, size == LEN, size < 1, size >= 3});
        check({tag, " sa.ov/un"}, {30'd0, bus_sa.overflow, bus_sa.underflow}, {30'd0, m_ov, m_un});
        check({tag, " rg.ov/un"}, {30'd0, bus_rg.overflow, bus_rg.underflow}, {30'd0, m_ov, m_un});
        if (size > 0) check({tag, " sa.q"}, 32'(bus_sa.q), 32'(mq[0]));
        check({tag, " rg.q"}, 32'(bus_rg.q), 32'(m_last));
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [WORD-1:0] d, input int usedw,
                                input logic empty, input logic full, input logic af, input logic ov, input logic un,
                                input logic q_sa_care, input logic [WORD-1:0] q_sa, input logic [WORD-1:0] q_rg);
        vec_t v;
        v.wr = wr; v.rd = rd; v.d = d; v.usedw = usedw; v.empty = empty; v.full = full; v.af = af;
        v.ov = ov; v.un = un; v.q_sa_care = q_sa_care; v.q_sa = q_sa; v.q_rg = q_rg;
        return v;
    endfunction

    initial begin
        // Fill to full, overflow once, then drain past empty to provoke underflow.
        tbl[0] = mk(1, 0, 16'hA1, 1, 0, 0, 0, 0, 0, 1, 16'hA1, 16'h0);
        tbl[1] = mk(1, 0, 16'hA2, 2, 0, 0, 0, 0, 0, 1, 16'hA1, 16'h0);
        tbl[2] = mk(1, 0, 16'hA3, 3, 0, 0, 1, 0, 0, 1, 16'hA1, 16'h0);
        tbl[3] = mk(1, 0, 16'hA4, 4, 0, 1, 1, 0, 0, 1, 16'hA1, 16'h0);
        tbl[4] = mk(1, 0, 16'hA5, 4, 0, 1, 1, 1, 0, 1, 16'hA1, 16'h0);
        tbl[5] = mk(0, 1, 16'h00, 3, 0, 0, 1, 1, 0, 1, 16'hA2, 16'hA1);
        tbl[6] = mk(0, 1, 16'h00, 2, 0, 0, 0, 1, 0, 1, 16'hA3, 16'hA2);
        tbl[7] = mk(0, 1, 16'h00, 1, 0, 0, 0, 1, 0, 1, 16'hA4, 16'hA3);
        tbl[8] = mk(0, 1, 16'h00, 0, 1, 0, 0, 1, 0, 0, 16'h00, 16'hA4);
        tbl[9] = mk(0, 1, 16'h00, 0, 1, 0, 0, 1, 1, 0, 16'h00, 16'hA4);

        bus_sa.wrreq = 0; bus_sa.rdreq = 0; bus_sa.data = '0;
        bus_rg.wrreq = 0; bus_rg.rdreq = 0; bus_rg.data = '0;
        model_reset();

        #12;
        check("reset sa.usedw", 32'(bus_sa.usedw), 32'd0);
        check("reset sa.flags", {28'd0, bus_sa.empty, bus_sa.full, bus_sa.almost_empty, bus_sa.almost_full}, 32'b1010);
        check("reset ov/un", {28'd0, bus_sa.overflow, bus_sa.underflow, bus_rg.overflow, bus_rg.underflow}, 32'd0);
        check("reset sa.q", 32'(bus_sa.q), 32'd0);
        check("reset rg.q", 32'(bus_rg.q), 32'd0);
        rst_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].wr, tbl[i].rd, 1'b0, tbl[i].d);
            check($sformatf("vec%0d usedw", i), 32'(bus_sa.usedw), 32'(tbl[i].usedw));
            check($sformatf("vec%0d e/f/af", i), {29'd0, bus_sa.empty, bus_sa.full, bus_sa.almost_full},
                  {29'd0, tbl[i].empty, tbl[i].full, tbl[i].af});
            check($sformatf("vec%0d ov/un", i), {30'd0, bus_sa.overflow, bus_sa.underflow}, {30'd0, tbl[i].ov, tbl[i].un});
            if (tbl[i].q_sa_care) check($sformatf("vec%0d sa.q", i), 32'(bus_sa.q), 32'(tbl[i].q_sa));
            check($sformatf("vec%0d rg.q", i), 32'(bus_rg.q), 32'(tbl[i].q_rg));
            check_all($sformatf("vec%0d", i));
        end

        // Registered read: data appears at the read edge and then holds.
        step(0, 0, 1, 16'h0);
        check("reg clr q", 32'(bus_rg.q), 32'd0);
        step(1, 0, 0, 16'h1234);
        check("reg before read q", 32'(bus_rg.q), 32'd0);
        step(0, 1, 0, 16'h0);
        check("reg read q", 32'(bus_rg.q), 32'h1234);
        step(0, 0, 0, 16'h0);
        check("reg hold q", 32'(bus_rg.q), 32'h1234);
        check_all("reg");

        // Simultaneous read/write at usedw=2 across several pointer wraps.
        step(0, 0, 1, 16'h0);
        step(1, 0, 0, 16'hB0);
        step(1, 0, 0, 16'hB1);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 16'(16'hC0 + i));
            check($sformatf("wrap%0d usedw", i), 32'(bus_sa.usedw), 32'd2);
            check($sformatf("wrap%0d sa.q", i), 32'(bus_sa.q), (i == 0) ? 32'hB1 : 32'(16'hC0 + i - 1));
            check($sformatf("wrap%0d rg.q", i), 32'(bus_rg.q),
                  (i == 0) ? 32'hB0 : (i == 1) ? 32'hB1 : 32'(16'hC0 + i - 2));
            check_all($sformatf("wrap%0d", i));
        end

        // Full with both requests, then empty with both requests.
        step(0, 0, 1, 16'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'(16'hD0 + i));
        step(1, 1, 0, 16'hDF);
        check("full rw usedw", 32'(bus_sa.usedw), 32'd3);
        check("full rw ov", 32'(bus_sa.overflow), 32'd1);
        check("full rw sa.q", 32'(bus_sa.q), 32'hD1);
        check_all("full rw");
        step(0, 0, 1, 16'h0);
        step(1, 1, 0, 16'hE7);
        check("empty rw usedw", 32'(bus_sa.usedw), 32'd1);
        check("empty rw un", 32'(bus_sa.underflow), 32'd1);
        check("empty rw sa.q", 32'(bus_sa.q), 32'hE7);
        check_all("empty rw");

        // sclr overrides a concurrent write and clears sticky flags.
        step(0, 0, 1, 16'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'(16'hF0 + i));
        step(1, 1, 0, 16'hFF);
        check("pre-clr usedw/ov", {28'd0, bus_sa.usedw, bus_sa.overflow}, {28'd0, 3'd3, 1'b1});
        step(1, 0, 1, 16'h55);
        check("clr usedw", 32'(bus_sa.usedw), 32'd0);
        check("clr empty/ov", {30'd0, bus_sa.empty, bus_sa.overflow}, 32'b10);
        check_all("clr");

        // Asynchronous reset mid-cycle on a non-empty FIFO with overflow set.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 16'(16'h70 + i));
        step(0, 1, 0, 16'h0);
        check("pre-rst usedw", 32'(bus_sa.usedw), 32'd3);
        bus_sa.rdreq = 0; bus_rg.rdreq = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst sa.usedw", 32'(bus_sa.usedw), 32'd0);
        check("async rst flags", {28'd0, bus_sa.empty, bus_sa.full, bus_sa.overflow, bus_rg.usedw == 3'd0}, 32'b1001);
        check("async rst q", {bus_sa.q, bus_rg.q}, 32'd0);
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock); #1;

        // Randomized traffic with occasional synchronous clears.
        for (int i = 0; i < 400; i++) begin
            logic wr, rd, clr;
            wr  = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 50);
            clr = ($urandom_range(0, 59) == 0);
            step(wr, rd, clr, 16'($urandom));
            check_all($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
